// File: rtl/dm_arbiter.sv
// Two-port arbiter sharing a single-ported data memory between the CPU (port 0)
// and the image-load/accelerator port (port 1). Build option: DM_ARB_FIXED_PRI_EN.
module dm_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_re,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_wrt_data,
    input  logic [DATA_W-1:0] dm_rd_data
);

    typedef enum logic {
        S_ARB,
        S_LOCK1
    } state_t;

    state_t            r_state;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rvalid0;
    logic              r_rvalid1;

    logic              w_sel1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // A lock only holds while port 1 keeps both req1 and lock1 high; otherwise
    // the cycle is arbitrated normally even while still in S_LOCK1.
    always_comb begin
        w_sel1 = 1'b0;
        if (r_state == S_LOCK1 && req1 && lock1) begin
            w_sel1 = 1'b1;
        end else if (req0 && req1) begin
`ifdef DM_ARB_FIXED_PRI_EN
            w_sel1 = 1'b0;
`else
            w_sel1 = ~r_last;
`endif
        end else begin
            w_sel1 = req1;
        end
    end

    assign w_gnt0  = req0 & ~w_sel1 & ~rst;
    assign w_gnt1  = req1 &  w_sel1 & ~rst;
    assign w_any   = w_gnt0 | w_gnt1;
    assign w_we    = w_sel1 ? we1    : we0;
    assign w_addr  = w_sel1 ? addr1  : addr0;
    assign w_wdata = w_sel1 ? wdata1 : wdata0;

    assign gnt0        = w_gnt0;
    assign gnt1        = w_gnt1;
    assign dm_we       = w_any & w_we;
    assign dm_re       = w_any & ~w_we;
    assign dm_addr     = w_any ? w_addr  : r_addr;
    assign dm_wrt_data = w_any ? w_wdata : r_wdata;
    assign rvalid0     = r_rvalid0;
    assign rvalid1     = r_rvalid1;
    assign rdata       = dm_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_ARB;
            r_last    <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~we0;
            r_rvalid1 <= w_gnt1 & ~we1;
            r_state   <= (w_gnt1 && lock1) ? S_LOCK1 : S_ARB;
            if (w_any) begin
                r_last  <= w_gnt1;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a per-cycle reference model pushes expected
// responses; an independent monitor pops and compares against the DUT.
module tb_dm_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
`ifdef DM_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, dm_re, dm_we;
    logic [DW-1:0] rdata, dm_wrt_data;
    logic [DW-1:0] dm_rd_data = '0;
    logic [AW-1:0] dm_addr;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we),
        .dm_wrt_data(dm_wrt_data), .dm_rd_data(dm_rd_data)
    );

    // Behavioural single-port memory, sampled on the falling edge
    logic [DW-1:0] dm_mem [0:(1<<AW)-1];
    always @(negedge clk) begin
        if (dm_we)      dm_mem[dm_addr] <= dm_wrt_data;
        else if (dm_re) dm_rd_data      <= dm_mem[dm_addr];
    end

    typedef struct {
        bit            rst;
        bit            g0, g1, re, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            rv0, rv1;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   mon_cyc = 0;

    // Reference model state: who owns a burst, who was served last,
    // what DM pins idle at, and a read whose result is due next cycle.
    bit            m_lock, m_last, m_pv, m_pp;
    logic [AW-1:0] m_ha;
    logic [DW-1:0] m_hd, m_pd;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] init_word(int unsigned a);
        if (a == 5) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, mon_cyc, act, req);
        end
    endtask

    task automatic step(input bit r,
                        input bit q0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit q1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input bit l1, output int win);
        exp_t          e;
        bit            wsel;
        logic [AW-1:0] asel;
        logic [DW-1:0] dsel;
        @(posedge clk);
        #1;
        rst = r; req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        e.rst = r;
        e.rv0 = m_pv && !m_pp;
        e.rv1 = m_pv && m_pp;
        e.rd  = m_pd;
        win = -1;
        if (!r) begin
            if (m_lock && q1 && l1)  win = 1;
            else if (q0 && q1)       win = (FIXED || m_last) ? 0 : 1;
            else if (q0)             win = 0;
            else if (q1)             win = 1;
        end
        wsel = (win == 1) ? w1 : w0;
        asel = (win == 1) ? a1 : a0;
        dsel = (win == 1) ? d1 : d0;
        e.g0 = (win == 0);
        e.g1 = (win == 1);
        if (win >= 0) begin
            e.we = wsel; e.re = !wsel; e.a = asel; e.d = dsel;
        end else begin
            e.we = 1'b0; e.re = 1'b0; e.a = m_ha; e.d = m_hd;
        end
        exp_q.push_back(e);
        m_pv = 1'b0;
        if (r) begin
            m_lock = 1'b0; m_last = 1'b1; m_ha = '0; m_hd = '0;
        end else begin
            m_lock = (win == 1) && l1;
            if (win >= 0) begin
                m_last = (win == 1);
                m_ha = asel; m_hd = dsel;
                if (wsel) ref_mem[asel] = dsel;
                else begin
                    m_pv = 1'b1; m_pp = (win == 1); m_pd = ref_mem[asel];
                end
            end
        end
    endtask

    exp_t me;
    always @(posedge clk) begin
        #4;
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            mon_cyc++;
            chk("gnt0", 64'(gnt0), 64'(me.g0));
            chk("gnt1", 64'(gnt1), 64'(me.g1));
            chk("dm_re", 64'(dm_re), 64'(me.re));
            chk("dm_we", 64'(dm_we), 64'(me.we));
            chk("re_we_exclusive", 64'(dm_re & dm_we), 64'd0);
            chk("dm_addr", 64'(dm_addr), 64'(me.a));
            chk("dm_wrt_data", 64'(dm_wrt_data), 64'(me.d));
            if (!me.rst) begin
                chk("rvalid0", 64'(rvalid0), 64'(me.rv0));
                chk("rvalid1", 64'(rvalid1), 64'(me.rv1));
                if (me.rv0 || me.rv1) chk("rdata", 64'(rdata), 64'(me.rd));
            end
        end
    end

    task automatic idle(input bit r);
        int w;
        step(r, 0, 0, '0, '0, 0, 0, '0, '0, 0, w);
    endtask

    initial begin
        int            w;
        bit            p0v, p0w, p1v, p1w, l1, r;
        logic [AW-1:0] p0a, p1a;
        logic [DW-1:0] p0d, p1d;

        for (int unsigned i = 0; i < (1 << AW); i++) begin
            dm_mem[i]  = init_word(i);
            ref_mem[i] = init_word(i);
        end
        m_lock = 1'b0; m_last = 1'b1; m_pv = 1'b0; m_pp = 1'b0;
        m_ha = '0; m_hd = '0; m_pd = '0;
        repeat (2) @(posedge clk);

        // Reset values, then a single port-0 read of DM[5]
        idle(0);
        step(0, 1, 0, 13'h0005, '0, 0, 0, '0, '0, 0, w);
        idle(0);

        // Both ports reading continuously from a fresh tie state
        idle(1);
        repeat (6) step(0, 1, 0, 13'h0010, '0, 1, 0, 13'h0020, '0, 0, w);
        idle(0);

        // Locked 4-cycle write burst on port 1 while port 0 keeps requesting
        step(0, 1, 0, 13'h0030, '0, 0, 0, '0, '0, 0, w);
        repeat (4) step(0, 1, 0, 13'h0031, '0, 1, 1, 13'h1FFF, 32'h12345678, 1, w);
        step(0, 1, 0, 13'h0031, '0, 0, 0, '0, '0, 0, w);
        idle(0);

        // Write then read of the same word from opposite ports
        step(0, 1, 1, 13'h0100, 32'hA5A5A5A5, 0, 0, '0, '0, 0, w);
        step(0, 0, 0, '0, '0, 1, 0, 13'h0100, '0, 0, w);
        idle(0);

        // Reset lands in a locked read burst with a read granted just before
        step(0, 0, 0, '0, '0, 1, 0, 13'h0040, '0, 1, w);
        step(0, 0, 0, '0, '0, 1, 0, 13'h0041, '0, 1, w);
        step(1, 0, 0, '0, '0, 1, 0, 13'h0042, '0, 1, w);
        idle(0);
        step(0, 1, 0, 13'h0050, '0, 1, 0, 13'h0060, '0, 0, w);
        idle(0);

        // Randomised traffic; requesters hold until the model grants them
        p0v = 0; p1v = 0;
        p0w = 0; p1w = 0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!p0v && $urandom_range(0, 2) != 0) begin
                p0v = 1; p0w = $urandom_range(0, 1) == 1;
                p0a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                p0d = $urandom;
            end
            if (!p1v && $urandom_range(0, 2) != 0) begin
                p1v = 1; p1w = $urandom_range(0, 1) == 1;
                p1a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                p1d = $urandom;
            end
            l1 = $urandom_range(0, 2) != 0;
            r  = $urandom_range(0, 199) == 0;
            step(r, p0v, p0w, p0a, p0d, p1v, p1w, p1a, p1d, l1, w);
            if (w == 0) p0v = 0;
            if (w == 1) p1v = 0;
            if (r) begin p0v = 0; p1v = 0; end
        end
        idle(0);
        idle(0);
        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
